// File: rtl/kypd_scan_ctrl_if.sv
// Key event channel between the keypad scanner and its consumer.
//   key_code  : code of the most recent press event
//   key_valid : press event pending, held until acknowledged
//   key_ack   : consumer acknowledge, single-cycle pulse
//   key_held  : debounced stable state is a single key
//   overrun   : sticky, a press event replaced an unacknowledged one
interface kypd_scan_ctrl_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun,
        output key_ack
    );
endinterface

// File: rtl/kypd_scan_ctrl.sv
// 4x4 keypad scanner: drives columns one-hot low, samples synchronised rows,
// debounces whole scan frames and emits single press events with valid/ack.
//   clk, rst_n : system clock, async active-low reset
//   row_n      : keypad rows, active-low, asynchronous to clk
//   col_n      : column drive, one-hot low
//   key_if     : key event channel (master side)
module kypd_scan_ctrl #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              row_n,
    output logic [3:0]              col_n,
    kypd_scan_ctrl_if.master        key_if
);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    // Nibble i holds the code of the key at column i/4, row i%4.
    localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;

    logic [3:0]       row_s1, row_s2;
    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic [3:0][3:0]  frame;        // frame[col][row], 1 = pressed
    logic             eval_pend;    // frame just completed, evaluate this edge

    res_t             res_kind, prev_kind, prev_kind_nxt;
    logic [3:0]       res_code, prev_code, prev_code_nxt;
    logic [CNT_W-1:0] db_cnt, cnt_nxt;
    logic [3:0]       stable_code, stable_code_nxt;
    logic             held_nxt, valid_nxt, ovr_nxt, press;
    logic [3:0]       code_nxt;
    logic [15:0]      frame_flat;
    logic [4:0]       hits;

    // Row synchroniser, column sequencing and frame capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            div       <= '0;
            col_idx   <= '0;
            col_n     <= 4'b1110;
            frame     <= '0;
            eval_pend <= 1'b0;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
            if (div == DIV_LAST) begin
                div            <= '0;
                frame[col_idx] <= ~row_s2;
                col_idx        <= 2'(col_idx + 2'd1);
                col_n          <= {col_n[2:0], col_n[3]};
                eval_pend      <= (col_idx == 2'd3);
            end else begin
                div       <= DIV_W'(div + 1'b1);
                eval_pend <= 1'b0;
            end
        end
    end

    // Classify the completed frame: none, exactly one key, or several.
    always_comb begin
        frame_flat = frame;
        hits       = '0;
        res_code   = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_flat[i]) begin
                hits     = 5'(hits + 5'd1);
                res_code = KEY_MAP[i*4 +: 4];
            end
        end
        if (hits == 5'd0)      res_kind = RES_NONE;
        else if (hits == 5'd1) res_kind = RES_KEY;
        else                   res_kind = RES_MULTI;
    end

    // Debounce / stable-state / handshake next-state logic.
    always_comb begin
        prev_kind_nxt   = prev_kind;
        prev_code_nxt   = prev_code;
        cnt_nxt         = db_cnt;
        held_nxt        = key_if.key_held;
        stable_code_nxt = stable_code;
        press           = 1'b0;
        code_nxt        = key_if.key_code;
        valid_nxt       = key_if.key_valid;
        ovr_nxt         = key_if.overrun;

        if (eval_pend) begin
            prev_kind_nxt = res_kind;
            prev_code_nxt = res_code;
            if (res_kind == RES_MULTI) begin
                cnt_nxt = '0;
            end else begin
                if (res_kind == prev_kind && (res_kind == RES_NONE || res_code == prev_code))
                    cnt_nxt = (db_cnt == CNT_MAX) ? db_cnt : CNT_W'(db_cnt + 1'b1);
                else
                    cnt_nxt = CNT_W'(1);
                if (cnt_nxt == CNT_MAX) begin
                    if (res_kind == RES_NONE) begin
                        held_nxt = 1'b0;
                    end else if (!key_if.key_held || res_code != stable_code) begin
                        held_nxt        = 1'b1;
                        stable_code_nxt = res_code;
                        press           = 1'b1;
                    end
                end
            end
        end

        // A new event always wins over a coincident ack; the ack still
        // counts as having consumed the previous event.
        if (press) begin
            code_nxt  = res_code;
            valid_nxt = 1'b1;
            if (key_if.key_valid) ovr_nxt = !key_if.key_ack;
        end else if (key_if.key_ack && key_if.key_valid) begin
            valid_nxt = 1'b0;
            ovr_nxt   = 1'b0;
        end
    end

    // Debounce state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_kind        <= RES_NONE;
            prev_code        <= '0;
            db_cnt           <= '0;
            stable_code      <= '0;
            key_if.key_held  <= 1'b0;
            key_if.key_code  <= '0;
            key_if.key_valid <= 1'b0;
            key_if.overrun   <= 1'b0;
        end else begin
            prev_kind        <= prev_kind_nxt;
            prev_code        <= prev_code_nxt;
            db_cnt           <= cnt_nxt;
            stable_code      <= stable_code_nxt;
            key_if.key_held  <= held_nxt;
            key_if.key_code  <= code_nxt;
            key_if.key_valid <= valid_nxt;
            key_if.overrun   <= ovr_nxt;
        end
    end
endmodule
